jbi_mout_int_arb: RTL



---
 rtl/jbi_mout_int_arb_pkg.sv | 44 ++++
 rtl/jbi_mout_int_arb_if.sv | 35 +++
 rtl/jbi_mout_rr5.sv | 30 +++
 rtl/jbi_mout_int_arb.sv | 127 ++++++++++++
 4 files changed

// File: rtl/jbi_mout_int_arb_pkg.sv
// jbi_mout internal arbiter: shared queue bit map,
// packet type codes, state encoding and pointer helper.
package jbi_mout_int_arb_pkg;

  localparam int NQ  = 7;
  localparam int NRR = 5;

  localparam int LRQ_DBGQ_BIT    = 0;
  localparam int LRQ_SCT0RDQ_BIT = 1;
  localparam int LRQ_SCT1RDQ_BIT = 2;
  localparam int LRQ_SCT2RDQ_BIT = 3;
  localparam int LRQ_SCT3RDQ_BIT = 4;
  localparam int LRQ_PIORQQ_BIT  = 5;
  localparam int LRQ_PIOACKQ_BIT = 6;

  localparam logic [3:0] T_NONE    = 4'h0;
  localparam logic [3:0] T_RD16    = 4'h1;
  localparam logic [3:0] T_RD64    = 4'h2;
  localparam logic [3:0] T_RDER    = 4'h3;
  localparam logic [3:0] T_WRI     = 4'h4;
  localparam logic [3:0] T_WR8     = 4'h5;
  localparam logic [3:0] T_WR64    = 4'h6;
  localparam logic [3:0] T_INT_ACK = 4'h7;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HOLD,
    ST_BUBBLE
  } arb_state_e;

  // Pointer moves one past the granted round-robin bit, 5 wraps to 1.
  function automatic logic [2:0] rr_next(
    input logic [NQ-1:0] sel,
    input logic [2:0]    ptr
  );
    rr_next = ptr;
    for (int b = 1; b <= NRR; b++) begin
      if (sel[b]) begin
        rr_next = (b == NRR) ? 3'd1 : 3'(b + 1);
      end
    end
  endfunction

endpackage

// File: rtl/jbi_mout_int_arb_if.sv
// Queue-side and packet-controller-side signals of
// the jbi_mout internal arbiter.
interface jbi_mout_int_arb_if
  import jbi_mout_int_arb_pkg::*;
();

  logic [NQ-1:0]   queue_req;
  logic [4*NQ-1:0] queue_type;
  logic [NQ-1:0]   queue_pkt_avail;
  logic            int_granted;
  logic [NQ-1:0]   int_requestors;
  logic [3:0]      int_req_type;
  logic            multiple_ok;

  modport master (
    input  queue_req,
    input  queue_type,
    input  queue_pkt_avail,
    input  int_granted,
    output int_requestors,
    output int_req_type,
    output multiple_ok
  );

  modport slave (
    output queue_req,
    output queue_type,
    output queue_pkt_avail,
    output int_granted,
    input  int_requestors,
    input  int_req_type,
    input  multiple_ok
  );

endinterface

// File: rtl/jbi_mout_rr5.sv
// 5-way round-robin picker: first requester at or
// after i_ptr (index into i_req) gets the one-hot grant.
module jbi_mout_rr5
  import jbi_mout_int_arb_pkg::*;
(
  input  logic [NRR-1:0] i_req,
  input  logic [2:0]     i_ptr,
  output logic [NRR-1:0] o_gnt
);

  logic [3:0] w_pos;
  logic       w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < NRR; i++) begin
      w_pos = {1'b0, i_ptr} + 4'(i);
      if (w_pos >= 4'(NRR)) begin
        w_pos = w_pos - 4'(NRR);
      end
      if (!w_found && i_req[w_pos[2:0]]) begin
        o_gnt[w_pos[2:0]] = 1'b1;
        w_found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jbi_mout_int_arb.sv
// JBus outbound internal request arbiter: picks one of
// seven queues and holds it until the controller grants.
module jbi_mout_int_arb
  import jbi_mout_int_arb_pkg::*;
#(
  parameter int DBG_STARVE_MAX = 16
) (
  input logic               clk,
  input logic               rst_l,
  jbi_mout_int_arb_if.master bus
);

  localparam logic [4:0] LP_MAX = 5'(DBG_STARVE_MAX);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic [NQ-1:0]  r_sel;
  logic [NQ-1:0]  w_sel_nxt;
  logic [NQ-1:0]  w_win;
  logic [3:0]     r_type;
  logic [3:0]     w_type_nxt;
  logic [3:0]     w_win_type;
  logic [2:0]     r_rr_ptr;
  logic [2:0]     w_rr_ptr_nxt;
  logic [2:0]     w_rr_idx;
  logic [4:0]     r_starve;
  logic [4:0]     w_starve_nxt;
  logic [NRR-1:0] w_rr_gnt;
  logic           w_dbg_starved;

  assign w_rr_idx =
    (r_rr_ptr >= 3'd1 && r_rr_ptr <= 3'd5) ?
    r_rr_ptr - 3'd1 : 3'd0;

  jbi_mout_rr5 u_rr5 (
    .i_req (bus.queue_req[LRQ_PIORQQ_BIT:LRQ_SCT0RDQ_BIT]),
    .i_ptr (w_rr_idx),
    .o_gnt (w_rr_gnt)
  );

  assign w_dbg_starved =
    bus.queue_req[LRQ_DBGQ_BIT] && (r_starve >= LP_MAX);

  // Overlapping requests resolve by position, hence if/else.
  always_comb begin
    w_win = '0;
    if (bus.queue_req[LRQ_PIOACKQ_BIT]) begin
      w_win[LRQ_PIOACKQ_BIT] = 1'b1;
    end else if (w_dbg_starved) begin
      w_win[LRQ_DBGQ_BIT] = 1'b1;
    end else if (|bus.queue_req[LRQ_PIORQQ_BIT:LRQ_SCT0RDQ_BIT]) begin
      w_win[LRQ_PIORQQ_BIT:LRQ_SCT0RDQ_BIT] = w_rr_gnt;
    end else if (bus.queue_req[LRQ_DBGQ_BIT]) begin
      w_win[LRQ_DBGQ_BIT] = 1'b1;
    end
  end

  always_comb begin
    w_win_type = T_NONE;
    for (int n = 0; n < NQ; n++) begin
      if (w_win[n]) begin
        w_win_type = bus.queue_type[4*n +: 4];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_type_nxt   = r_type;
    w_rr_ptr_nxt = r_rr_ptr;
    w_starve_nxt = r_starve;
    unique case (r_state)
      ST_EMPTY: begin
        if (|bus.queue_req) begin
          w_state_nxt = ST_HOLD;
          w_sel_nxt   = w_win;
          w_type_nxt  = w_win_type;
        end
      end
      ST_HOLD: begin
        if (bus.int_granted) begin
          w_state_nxt  = ST_BUBBLE;
          w_sel_nxt    = '0;
          w_type_nxt   = T_NONE;
          w_rr_ptr_nxt = rr_next(r_sel, r_rr_ptr);
          if (r_sel[LRQ_DBGQ_BIT]) begin
            w_starve_nxt = '0;
          end else if (bus.queue_req[LRQ_DBGQ_BIT] &&
                       r_starve < LP_MAX) begin
            w_starve_nxt = r_starve + 5'd1;
          end
        end
      end
      ST_BUBBLE: begin
        w_state_nxt = ST_EMPTY;
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_sel_nxt   = '0;
        w_type_nxt  = T_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state  <= ST_EMPTY;
      r_sel    <= '0;
      r_type   <= T_NONE;
      r_rr_ptr <= 3'd1;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_type   <= w_type_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  assign bus.int_requestors = r_sel;
  assign bus.int_req_type   = r_type;
  assign bus.multiple_ok    = |(r_sel & bus.queue_pkt_avail);

endmodule
